// File: rtl/feature_pkg.sv
// Shared definitions for the stroke feature extractor: token encodings,
// default count widths and the output-stage state type.
package feature_pkg;

    localparam int unsigned EW_DEF = 3;
    localparam int unsigned CW_DEF = 4;
    localparam int unsigned TOK_W  = 2;

    localparam logic [TOK_W-1:0] TOK_PAD   = 2'b00;
    localparam logic [TOK_W-1:0] TOK_EDGE  = 2'b01;
    localparam logic [TOK_W-1:0] TOK_CURVE = 2'b10;
    localparam logic [TOK_W-1:0] TOK_END   = 2'b11;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/feature_extractor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: i_clk, i_rst (sync, active-high), i_clr (sync clear), i_inc (count
// request), o_count (current value), o_hit_c (increment requested at maximum).
module sat_counter #(
    parameter int unsigned W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_hit_c
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] r_count;

    // Count register; holds at MAX instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_hit_c = i_inc && (r_count == MAX);

endmodule

// File: rtl/feature_extractor.sv
// Stroke feature extractor: counts EDGE and CURVE tokens per frame and, on END,
// hands the completed (edges, curves, ovf) vector to a ready/valid consumer.
// Ports: clk, rst (sync, active-high); tok_valid/tok/tok_ready token input;
// feat_valid/feat_ready vector handshake; edges, curves, ovf held vector;
// frames count of vectors handed off (mod 256).
module feature_extractor
    import feature_pkg::*;
#(
    parameter int unsigned EW = EW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tok_valid,
    input  logic [TOK_W-1:0] tok,
    output logic             tok_ready,
    output logic             feat_valid,
    input  logic             feat_ready,
    output logic [EW-1:0]    edges,
    output logic [CW-1:0]    curves,
    output logic             ovf,
    output logic [7:0]       frames
);

    state_t        r_state;
    state_t        w_state_nxt;

    logic          w_tok_acc;
    logic          w_edge;
    logic          w_curve;
    logic          w_end;
    logic          w_feat_hs;
    logic          w_hit_e;
    logic          w_hit_c;
    logic [EW-1:0] w_acc_e;
    logic [CW-1:0] w_acc_c;
    logic          r_acc_ovf;

    logic [EW-1:0] r_edges;
    logic [CW-1:0] r_curves;
    logic          r_ovf;
    logic [7:0]    r_frames;

    // A token can be taken whenever the output slot is free or is being drained.
    assign tok_ready  = (r_state == S_EMPTY) || feat_ready;
    assign feat_valid = (r_state == S_FULL);

    assign w_tok_acc = tok_valid && tok_ready;
    assign w_edge    = w_tok_acc && (tok == TOK_EDGE);
    assign w_curve   = w_tok_acc && (tok == TOK_CURVE);
    assign w_end     = w_tok_acc && (tok == TOK_END);
    assign w_feat_hs = feat_valid && feat_ready;

    // In-progress frame accumulators.
    sat_counter #(.W(EW)) u_edge_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_end),
        .i_inc   (w_edge),
        .o_count (w_acc_e),
        .o_hit_c (w_hit_e)
    );

    sat_counter #(.W(CW)) u_curve_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_end),
        .i_inc   (w_curve),
        .o_count (w_acc_c),
        .o_hit_c (w_hit_c)
    );

    // Sticky overflow for the current frame.
    always_ff @(posedge clk) begin
        if (rst || w_end) begin
            r_acc_ovf <= 1'b0;
        end else if (w_hit_e || w_hit_c) begin
            r_acc_ovf <= 1'b1;
        end
    end

    // Output state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: END fills the slot; a drain without a refill empties it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_end) begin
            w_state_nxt = S_FULL;
        end else if (w_feat_hs) begin
            w_state_nxt = S_EMPTY;
        end
    end

    // Held vector; END only reaches here when the slot is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edges  <= '0;
            r_curves <= '0;
            r_ovf    <= 1'b0;
        end else if (w_end) begin
            r_edges  <= w_acc_e;
            r_curves <= w_acc_c;
            r_ovf    <= r_acc_ovf;
        end
    end

    // Handoff counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames <= '0;
        end else if (w_feat_hs) begin
            r_frames <= r_frames + 8'(1);
        end
    end

    assign edges  = r_edges;
    assign curves = r_curves;
    assign ovf    = r_ovf;
    assign frames = r_frames;

endmodule

// File: tb/tb_feature_extractor.sv
// Self-checking bench for feature_extractor: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_feature_extractor;

    localparam int EW   = 3;
    localparam int CW   = 4;
    localparam int EMAX = (1 << EW) - 1;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [1:0] PAD   = 2'b00;
    localparam logic [1:0] EDGE  = 2'b01;
    localparam logic [1:0] CURVE = 2'b10;
    localparam logic [1:0] ENDT  = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tok_valid = 1'b0;
    logic [1:0]    tok = 2'b00;
    logic          tok_ready;
    logic          feat_valid;
    logic          feat_ready = 1'b0;
    logic [EW-1:0] edges;
    logic [CW-1:0] curves;
    logic          ovf;
    logic [7:0]    frames;

    int checks = 0;
    int errors = 0;

    // Behavioural model: frame counts, held vector, slot occupancy.
    bit m_known = 0;
    int m_acc_e = 0, m_acc_c = 0, m_acc_ovf = 0;
    int m_e = 0, m_c = 0, m_ovf = 0, m_frames = 0, m_full = 0;

    feature_extractor #(.EW(EW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tok_valid  (tok_valid),
        .tok        (tok),
        .tok_ready  (tok_ready),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .edges      (edges),
        .curves     (curves),
        .ovf        (ovf),
        .frames     (frames)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (m_known) begin
            chk("feat_valid", int'(feat_valid), m_full);
            chk("edges", int'(edges), m_e);
            chk("curves", int'(curves), m_c);
            chk("ovf", int'(ovf), m_ovf);
            chk("frames", int'(frames), m_frames);
        end
    endtask

    // Apply what the next rising edge must do to the model.
    task automatic model_update(input bit r, input bit v, input logic [1:0] t, input bit fr);
        bit acc, hs;
        if (r) begin
            m_acc_e = 0; m_acc_c = 0; m_acc_ovf = 0;
            m_e = 0; m_c = 0; m_ovf = 0; m_frames = 0; m_full = 0;
            m_known = 1;
        end else begin
            acc = v && (m_full == 0 || fr);
            hs  = (m_full != 0) && fr;
            if (acc) begin
                case (t)
                    EDGE:  if (m_acc_e == EMAX) m_acc_ovf = 1; else m_acc_e++;
                    CURVE: if (m_acc_c == CMAX) m_acc_ovf = 1; else m_acc_c++;
                    ENDT: begin
                        m_e = m_acc_e; m_c = m_acc_c; m_ovf = m_acc_ovf;
                        m_acc_e = 0; m_acc_c = 0; m_acc_ovf = 0;
                    end
                    default: ;
                endcase
            end
            if (hs) m_frames = (m_frames + 1) % 256;
            if (acc && t == ENDT) m_full = 1;
            else if (hs) m_full = 0;
        end
    endtask

    // One cycle: check registered outputs, drive inputs, check tok_ready, advance model.
    task automatic step(input bit r, input bit v, input logic [1:0] t, input bit fr);
        @(negedge clk);
        compare_model();
        rst = r; tok_valid = v; tok = t; feat_ready = fr;
        #1;
        if (m_known) chk("tok_ready", int'(tok_ready), (m_full == 0 || fr) ? 1 : 0);
        model_update(r, v, t, fr);
    endtask

    task automatic send(input logic [1:0] t, input int n, input bit fr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, t, fr);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int held_frames;

        // Reset.
        step(1'b1, 1'b0, PAD, 1'b0);
        step(1'b1, 1'b1, ENDT, 1'b1);
        step(1'b0, 1'b0, PAD, 1'b0);
        settle();
        chk("rst feat_valid", int'(feat_valid), 0);
        chk("rst tok_ready", int'(tok_ready), 1);
        chk("rst frames", int'(frames), 0);
        chk("rst edges", int'(edges), 0);

        // CURVE x4, END, consumer always ready.
        send(CURVE, 4, 1'b1);
        send(ENDT, 1, 1'b1);
        settle();
        chk("c4 feat_valid", int'(feat_valid), 1);
        chk("c4 edges", int'(edges), 0);
        chk("c4 curves", int'(curves), 4);
        chk("c4 ovf", int'(ovf), 0);
        chk("c4 frames before", int'(frames), 0);
        step(1'b0, 1'b0, PAD, 1'b1);
        settle();
        chk("c4 frames after", int'(frames), 1);
        chk("c4 drained", int'(feat_valid), 0);

        // EDGE, PAD x3, END.
        send(EDGE, 1, 1'b0);
        send(PAD, 3, 1'b0);
        send(ENDT, 1, 1'b0);
        settle();
        chk("e1 edges", int'(edges), 1);
        chk("e1 curves", int'(curves), 0);
        chk("e1 ovf", int'(ovf), 0);
        step(1'b0, 1'b0, PAD, 1'b1);

        // EDGE x9 saturates, CURVE x2, END; following empty frame clears ovf.
        send(EDGE, 9, 1'b0);
        send(CURVE, 2, 1'b0);
        send(ENDT, 1, 1'b0);
        settle();
        chk("sat edges", int'(edges), 7);
        chk("sat curves", int'(curves), 2);
        chk("sat ovf", int'(ovf), 1);
        step(1'b0, 1'b0, PAD, 1'b1);
        send(ENDT, 1, 1'b0);
        settle();
        chk("empty edges", int'(edges), 0);
        chk("empty curves", int'(curves), 0);
        chk("empty ovf", int'(ovf), 0);
        step(1'b0, 1'b0, PAD, 1'b1);

        // Backpressure: hold a vector 5 cycles, then drain and refill in one cycle.
        send(EDGE, 2, 1'b0);
        send(CURVE, 1, 1'b0);
        send(ENDT, 1, 1'b0);
        settle();
        held_frames = int'(frames);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, EDGE, 1'b0);
            chk("bp tok_ready", int'(tok_ready), 0);
            settle();
            chk("bp feat_valid", int'(feat_valid), 1);
            chk("bp edges", int'(edges), 2);
            chk("bp curves", int'(curves), 1);
        end
        step(1'b0, 1'b1, ENDT, 1'b1);
        settle();
        chk("b2b feat_valid", int'(feat_valid), 1);
        chk("b2b edges", int'(edges), 0);
        chk("b2b curves", int'(curves), 0);
        chk("b2b frames", int'(frames), (held_frames + 1) % 256);
        step(1'b0, 1'b0, PAD, 1'b1);

        // Reset discards a held vector, then a partial frame.
        send(EDGE, 1, 1'b0);
        send(ENDT, 1, 1'b0);
        step(1'b1, 1'b1, EDGE, 1'b1);
        settle();
        chk("rst held feat_valid", int'(feat_valid), 0);
        chk("rst held frames", int'(frames), 0);
        chk("rst held tok_ready", int'(tok_ready), 1);
        send(EDGE, 3, 1'b0);
        step(1'b1, 1'b0, PAD, 1'b0);
        send(ENDT, 1, 1'b0);
        settle();
        chk("rst partial edges", int'(edges), 0);
        chk("rst partial feat_valid", int'(feat_valid), 1);
        step(1'b0, 1'b0, PAD, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0);
        end
        step(1'b0, 1'b0, PAD, 1'b0);
        @(negedge clk);
        compare_model();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
